// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   - SEG_A..SEG_G : bit positions of each segment within the 7-bit seg bus
//   - SEG_HEX      : active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   - off_level()  : the level at which a pin of the given polarity is dark
package seg7_pkg;

    localparam int SEG_A = 0;  // top
    localparam int SEG_B = 1;  // upper-right
    localparam int SEG_C = 2;  // lower-right
    localparam int SEG_D = 3;  // bottom
    localparam int SEG_E = 4;  // lower-left
    localparam int SEG_F = 5;  // upper-left
    localparam int SEG_G = 6;  // middle

    // Lower-case b and d keep 8/B and 0/D distinguishable.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        7'b1110111,  // A
        7'b1111100,  // b
        7'b0111001,  // C
        7'b1011110,  // d
        7'b1111001,  // E
        7'b1110001   // F
    };

    // A pin that is active-low is dark when driven high, and vice versa.
    function automatic logic off_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex digit to active-high segment pattern.
//   hex : 4-bit digit value
//   seg : {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a DIGITS-wide seven-segment bank.
//   clk, rst  : clock, asynchronous active-high reset
//   value     : packed hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in     : decimal-point request per digit
//   load      : capture value/dp_in into the shadow registers
//   enable    : 1 = scan and display, 0 = dark with the scan position frozen
//   blank_lz  : 1 = suppress leading zero digits (digit 0 is never blanked)
//   seg, dp   : segment lines and decimal point of the lit digit
//   an        : one-hot digit enable
// All outputs are registered; pins show the scan position and shadow contents
// as they stood before the most recent clock edge.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    localparam logic SEG_OFF = off_level(SEG_ACTIVE_LOW);
    localparam logic AN_OFF  = off_level(AN_ACTIVE_LOW);

    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   shadow_dp;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                tick;

    logic [DIGITS-1:0]   lit_onehot;
    logic [3:0]          cur_hex;
    logic                cur_dp;
    logic                upper_nonzero;
    logic                lz_blank;
    logic [6:0]          hex_seg;

    assign tick = enable && (cnt == CNT_LAST);

    // Shadow capture and scan position. Load is independent of the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
            cnt       <= '0;
            idx       <= '0;
        end else begin
            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_in;
            end
            if (enable) begin
                if (tick) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Select the lit digit and work out whether it is a leading zero: every
    // digit from idx up to the most significant one must be zero.
    always_comb begin
        lit_onehot    = '0;
        cur_hex       = 4'h0;
        cur_dp        = 1'b0;
        upper_nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                lit_onehot[i] = 1'b1;
                cur_hex       = shadow[4*i +: 4];
                cur_dp        = shadow_dp[i];
            end
            if ((IDX_W'(i) >= idx) && (shadow[4*i +: 4] != 4'h0)) begin
                upper_nonzero = 1'b1;
            end
        end
        lz_blank = blank_lz && (idx != '0) && !upper_nonzero;
    end

    seg7_hex_decode u_decode (
        .hex (cur_hex),
        .seg (hex_seg)
    );

    // Registered pin stage; polarity inversion is applied last so the
    // blanking and enable gating are written in active-high terms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= {7{SEG_OFF}};
            dp  <= SEG_OFF;
            an  <= {DIGITS{AN_OFF}};
        end else if (!enable) begin
            seg <= {7{SEG_OFF}};
            dp  <= SEG_OFF;
            an  <= {DIGITS{AN_OFF}};
        end else begin
            seg <= (lz_blank ? 7'h00 : hex_seg) ^ {7{SEG_OFF}};
            dp  <= cur_dp ^ SEG_OFF;
            an  <= lit_onehot ^ {DIGITS{AN_OFF}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. The main instance is 4 digits, SCAN_DIV=4,
// active-low digit enables; a second instance is a single digit with
// SCAN_DIV=1 and inverted segments. The reference model tracks the number of
// enabled cycles since reset: the lit digit is (cycles / SCAN_DIV) % DIGITS.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load, enable, blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    logic [3:0]  value1;
    logic        dp_in1, load1, enable1;
    logic [6:0]  seg1;
    logic        dp1;
    logic        an1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int          m_en;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [6:0]  tbl [16];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .enable(enable), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an)
    );

    seg7_scan_driver #(
        .DIGITS(1), .SCAN_DIV(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut1 (
        .clk(clk), .rst(rst), .value(value1), .dp_in(dp_in1), .load(load1),
        .enable(enable1), .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1)
    );

    task automatic model_reset();
        m_en  = 0;
        m_val = 16'h0000;
        m_dp  = 4'h0;
    endtask

    // One clock of the main instance: predict the pins that the coming edge
    // produces, advance the model, then check #1 after the edge.
    task automatic step(input string tag);
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        logic [3:0] nib;
        int         d;
        if (enable) begin
            d        = (m_en / SCAN_DIV) % DIGITS;
            nib      = 4'(m_val >> (4 * d));
            e_an     = 4'hF;
            e_an[d]  = 1'b0;
            e_seg    = tbl[nib];
            if (blank_lz && d != 0 && (m_val >> (4 * d)) == 16'h0) e_seg = 7'h00;
            e_dp     = m_dp[d];
        end else begin
            e_an  = 4'hF;
            e_seg = 7'h00;
            e_dp  = 1'b0;
        end
        if (load) begin
            m_val = value;
            m_dp  = dp_in;
        end
        if (enable) m_en++;
        @(posedge clk);
        #1;
        n_vec++;
        if (seg !== e_seg) begin
            n_err++;
            $display("FAIL %s seg: got %b expected %b (t=%0t)", tag, seg, e_seg, $time);
        end
        n_vec++;
        if (dp !== e_dp) begin
            n_err++;
            $display("FAIL %s dp: got %b expected %b (t=%0t)", tag, dp, e_dp, $time);
        end
        n_vec++;
        if (an !== e_an) begin
            n_err++;
            $display("FAIL %s an: got %b expected %b (t=%0t)", tag, an, e_an, $time);
        end
    endtask

    task automatic check_dark(input string tag);
        n_vec++;
        if (seg !== 7'h00 || dp !== 1'b0 || an !== 4'hF) begin
            n_err++;
            $display("FAIL %s main: got seg=%b dp=%b an=%b expected seg=0000000 dp=0 an=1111",
                     tag, seg, dp, an);
        end
        n_vec++;
        if (seg1 !== 7'h7F || dp1 !== 1'b1 || an1 !== 1'b1) begin
            n_err++;
            $display("FAIL %s single: got seg=%b dp=%b an=%b expected seg=1111111 dp=1 an=1",
                     tag, seg1, dp1, an1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset");
        model_reset();
        rst = 1'b0;
        repeat (3) step("reset_idle");
    endtask

    task automatic test_scan();
        value = 16'h12AF; dp_in = 4'h0; enable = 1'b1; blank_lz = 1'b0;
        load = 1'b1;
        step("scan_load");
        load = 1'b0;
        repeat (40) step("scan");
    endtask

    task automatic test_blank();
        value = 16'h0030; dp_in = 4'b1000; blank_lz = 1'b1;
        load = 1'b1;
        step("blank_load");
        load = 1'b0;
        repeat (32) step("blank_on");
        blank_lz = 1'b0;
        repeat (16) step("blank_off");
    endtask

    task automatic test_pause();
        int i;
        value = 16'h5E7C; dp_in = 4'b0100; load = 1'b1;
        step("pause_load");
        load = 1'b0;
        for (i = 0; i < 64 && !(((m_en / SCAN_DIV) % DIGITS) == 2 && (m_en % SCAN_DIV) == 1); i++)
            step("pause_seek");
        if (i == 64) begin
            n_vec++; n_err++;
            $display("FAIL pause_seek: got no digit-2 position expected one within 64 cycles");
        end
        enable = 1'b0;
        repeat (10) step("pause_off");
        enable = 1'b1;
        repeat (20) step("pause_resume");
    endtask

    task automatic test_load_on_tick();
        for (int k = 0; k < 4; k++) begin
            int i;
            for (i = 0; i < 16 && (m_en % SCAN_DIV) != SCAN_DIV - 1; i++) step("tick_seek");
            value = 16'($urandom); dp_in = 4'($urandom);
            load  = 1'b1;
            step("tick_load");
            load  = 1'b0;
            repeat (6) step("tick_after");
        end
    endtask

    task automatic test_random();
        repeat (300) begin
            value    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = 4'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            blank_lz = 1'($urandom_range(0, 1));
            step("random");
        end
        load = 1'b0; enable = 1'b1;
    endtask

    task automatic test_async_reset();
        int i;
        blank_lz = 1'b0; value = 16'hABCD; dp_in = 4'b1111; load = 1'b1;
        step("areset_load");
        load = 1'b0;
        for (i = 0; i < 64 && (m_en % (SCAN_DIV * DIGITS)) != 13; i++) step("areset_seek");
        if (i == 64) begin
            n_vec++; n_err++;
            $display("FAIL areset_seek: got no digit-3 position expected one within 64 cycles");
        end
        #3;
        rst = 1'b1;
        #1;
        check_dark("areset_mid");
        model_reset();
        #2;
        rst = 1'b0;
        repeat (12) step("areset_after");
    endtask

    task automatic test_single_digit();
        enable1 = 1'b1; dp_in1 = 1'b0; load1 = 1'b0;
        step("single_pre");
        n_vec++;
        if (seg1 !== ~tbl[0] || an1 !== 1'b0 || dp1 !== 1'b1) begin
            n_err++;
            $display("FAIL single_zero: got seg=%b an=%b dp=%b expected seg=%b an=0 dp=1",
                     seg1, an1, dp1, ~tbl[0]);
        end
        for (int k = 0; k < 20; k++) begin
            logic [3:0] v;
            logic       p;
            v = (k == 0) ? 4'h8 : 4'($urandom);
            p = 1'($urandom);
            value1 = v; dp_in1 = p; load1 = 1'b1;
            step("single_load");
            load1 = 1'b0;
            repeat (2) begin
                step("single_hold");
                n_vec++;
                if (seg1 !== ~tbl[v] || an1 !== 1'b0 || dp1 !== ~p) begin
                    n_err++;
                    $display("FAIL single_digit %h: got seg=%b an=%b dp=%b expected seg=%b an=0 dp=%b",
                             v, seg1, an1, dp1, ~tbl[v], ~p);
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = 7'b0111111; tbl[1]  = 7'b0000110; tbl[2]  = 7'b1011011; tbl[3]  = 7'b1001111;
        tbl[4]  = 7'b1100110; tbl[5]  = 7'b1101101; tbl[6]  = 7'b1111101; tbl[7]  = 7'b0000111;
        tbl[8]  = 7'b1111111; tbl[9]  = 7'b1101111; tbl[10] = 7'b1110111; tbl[11] = 7'b1111100;
        tbl[12] = 7'b0111001; tbl[13] = 7'b1011110; tbl[14] = 7'b1111001; tbl[15] = 7'b1110001;
        rst = 1'b1; value = '0; dp_in = '0; load = 1'b0; enable = 1'b0; blank_lz = 1'b0;
        value1 = '0; dp_in1 = 1'b0; load1 = 1'b0; enable1 = 1'b0;
        model_reset();

        test_reset();
        test_scan();
        test_blank();
        test_pause();
        test_load_on_tick();
        test_random();
        test_async_reset();
        test_single_digit();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
